// File: rtl/uart_rx_pkg.sv
// Shared FSM encoding, mid-bit sample offsets and parity helper for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    localparam int SMP_OFS_EARLY = -1;
    localparam int SMP_OFS_MID   = 0;
    localparam int SMP_OFS_LATE  = 1;

    localparam int MAX_DATA_W = 9;

    // Callers zero-extend narrower words; padding zeros do not change the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Host-side receive bus: one held word plus per-frame flags, valid/ready accepted.
interface uart_rx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_error;
    logic                  stop_error;
    logic                  overrun;
    logic                  break_det;

    modport master (
        output rx_data, rx_valid, parity_error, stop_error, overrun, break_det,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_error, stop_error, overrun, break_det,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Per-bit edge/bit counters and 3-sample majority voter; strobe marks the late sample,
// where maj_bit combines the two registered samples with the live synchronised line.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_s,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  sample_strobe,
    output logic                  maj_bit
);

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] t_early;
    logic [PRESCALE_W-1:0] t_mid;
    logic [PRESCALE_W-1:0] t_late;
    logic [PRESCALE_W-1:0] t_wrap;
    logic                  s_early;
    logic                  s_mid;

    assign mid     = prescale >> 1;
    assign t_early = mid + PRESCALE_W'(SMP_OFS_EARLY);
    assign t_mid   = mid + PRESCALE_W'(SMP_OFS_MID);
    assign t_late  = mid + PRESCALE_W'(SMP_OFS_LATE);
    assign t_wrap  = prescale - PRESCALE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            s_early  <= 1'b1;
            s_mid    <= 1'b1;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (edge_cnt == t_wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
            if (edge_cnt == t_early) s_early <= rx_s;
            if (edge_cnt == t_mid)   s_mid   <= rx_s;
        end
    end

    assign sample_strobe = en && (edge_cnt == t_late);
    assign maj_bit       = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver; rx_valid rises 1 cycle after the final stop decision (+SYNC_STAGES from pad).
// One-entry holding register: a frame completing while the held word is unaccepted is dropped with an overrun pulse.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    uart_rx_param_if.master       rx_bus
);

    localparam int BIT_W = 4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_t              state;
    logic [PRESCALE_W-1:0]  prescale_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   two_stop_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   par_err_q;
    logic                   stop_err_q;
    logic                   brk_q;
    logic                   stop_first_q;

    logic [PRESCALE_W-1:0]  edge_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   sample_strobe;
    logic                   maj_bit;
    logic                   wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign wrap = (edge_cnt == (prescale_q - PRESCALE_W'(1)));

    uart_rx_bit_timer #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .en            (state != IDLE),
        .clr           (state == IDLE),
        .prescale      (prescale_q),
        .rx_s          (rx_s),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .sample_strobe (sample_strobe),
        .maj_bit       (maj_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            prescale_q          <= '0;
            par_en_q            <= 1'b0;
            par_typ_q           <= 1'b0;
            two_stop_q          <= 1'b0;
            data_q              <= '0;
            par_err_q           <= 1'b0;
            stop_err_q          <= 1'b0;
            brk_q               <= 1'b0;
            stop_first_q        <= 1'b0;
            rx_bus.rx_data      <= '0;
            rx_bus.rx_valid     <= 1'b0;
            rx_bus.parity_error <= 1'b0;
            rx_bus.stop_error   <= 1'b0;
            rx_bus.overrun      <= 1'b0;
            rx_bus.break_det    <= 1'b0;
        end else begin
            rx_bus.overrun   <= 1'b0;
            rx_bus.break_det <= 1'b0;
            if (rx_bus.rx_valid && rx_bus.rx_ready) rx_bus.rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        prescale_q   <= prescale;
                        par_en_q     <= par_en;
                        par_typ_q    <= par_typ;
                        two_stop_q   <= two_stop;
                        par_err_q    <= 1'b0;
                        stop_err_q   <= 1'b0;
                        brk_q        <= 1'b1;
                        stop_first_q <= 1'b0;
                        state        <= START;
                    end
                end
                START: begin
                    if (sample_strobe && maj_bit) state <= IDLE;
                    else if (wrap)                state <= DATA;
                end
                DATA: begin
                    if (sample_strobe) begin
                        data_q <= {maj_bit, data_q[DATA_WIDTH-1:1]};
                        if (maj_bit) brk_q <= 1'b0;
                    end
                    if (wrap && bit_cnt == BIT_W'(DATA_WIDTH))
                        state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (sample_strobe) begin
                        if (maj_bit != expected_parity(MAX_DATA_W'(data_q), par_typ_q))
                            par_err_q <= 1'b1;
                        if (maj_bit) brk_q <= 1'b0;
                    end
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    // Leave on the final stop decision so a back-to-back start edge is caught.
                    if (sample_strobe) begin
                        if (!maj_bit) stop_err_q <= 1'b1;
                        else          brk_q      <= 1'b0;
                        if (two_stop_q && !stop_first_q) stop_first_q <= 1'b1;
                        else                             state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (brk_q) begin
                        rx_bus.break_det <= 1'b1;
                    end else if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
                        rx_bus.rx_data      <= data_q;
                        rx_bus.parity_error <= par_err_q;
                        rx_bus.stop_error   <= stop_err_q;
                        rx_bus.rx_valid     <= 1'b1;
                    end else begin
                        rx_bus.overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It generalises the fixed 8-bit receiver with:
- configurable data width
- runtime parity and 1/2 stop-bit selection
- 3-sample majority voting and start-glitch rejection
- break detection
- a one-entry valid/ready output holding register with overrun flagging

It sits between the RX pad synchroniser domain and the host-side register/FIFO logic.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9
PRESCALE_W, 6, width of the prescale port
SYNC_STAGES, 2, input synchroniser flops on rx_in, legal >=2

Ports:
clk  in  1  system clock
rst  in  1  reset
rx_in  in  1  serial line, idle high, asynchronous to clk
prescale  in  PRESCALE_W  clk cycles per bit, legal 4..2^PRESCALE_W-1
par_en  in  1  1 = parity bit present
par_typ  in  1  0 = even, 1 = odd
two_stop  in  1  1 = two stop bits
rx_data  out  DATA_WIDTH  received word, LSB first on line
rx_valid  out  1  rx_data/flags valid, held until accepted
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
parity_error  out  1  qualified by rx_valid
stop_error  out  1  qualified by rx_valid, any stop bit sampled 0
overrun  out  1  1-cycle pulse, completed frame dropped
break_det  out  1  1-cycle pulse on break frame

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset state:
  - all outputs 0, FSM in IDLE, counters 0.
  - synchroniser flops and sample registers 1.
- Reset mid-frame aborts the frame with no output.
- prescale, par_en, par_typ and two_stop are latched on the IDLE->START transition. Changes mid-frame have no effect.
- Bit timing:
  - edge_cnt runs 0..P-1 per bit (P = latched prescale); bit_cnt increments on wrap.
  - mid = P>>1. Samples are taken at edge_cnt = mid-1, mid, mid+1.
  - The majority result is registered at edge_cnt == mid+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE -> START on synchronised falling edge (sync rx == 0). edge_cnt starts at 0 that cycle.
- START: if majority == 1, it is a glitch -> IDLE, no output, no flags. At wrap -> DATA.
- DATA:
  - shifts the majority into bit index bit_cnt (LSB first).
  - After DATA_WIDTH bits, goes to PARITY if par_en, else STOP.
- PARITY:
  - expected = ^data if par_typ = 0, ~^data if par_typ = 1.
  - mismatch sets frame parity_error. At wrap -> STOP.
- STOP:
  - each stop bit majority 0 sets frame stop_error.
  - On the majority decision of the final stop bit (1st or 2nd per two_stop) -> DONE immediately, without waiting for the wrap. This allows resync to a back-to-back start edge.
- DONE (1 cycle) -> IDLE. Delivery happens in DONE.
- Break:
  - condition: all data bits 0, parity bit 0 (if enabled), and all stop bits 0.
  - response: break_det pulses for one cycle in DONE. Nothing is delivered, error flags are unchanged, and overrun is not raised.
- Delivery in DONE:
  - if rx_valid == 0 or (rx_valid & rx_ready) that cycle, load rx_data, parity_error and stop_error, and set rx_valid = 1.
  - otherwise (rx_valid & !rx_ready): pulse overrun for one cycle, drop the new frame, and leave the held word/flags untouched.
- rx_valid clears on the cycle after a handshake, unless a reload occurs in that same cycle.
- Latency: rx_valid rises 1 cycle after the final stop-bit majority decision. Measured from the start falling edge at the pad, add SYNC_STAGES cycles.

Decomposition:
- Package uart_rx_pkg contains:
  - the state enum (IDLE..DONE, 3 bits)
  - constants for the sample offsets (-1, 0, +1)
  - a parity-function helper
- One sub-module, uart_rx_bit_timer: the edge/bit counters plus the 3-sample majority voter.
  - outputs: edge_cnt, bit_cnt, sample_strobe (1 cycle at mid+1), maj_bit.
  - controlled by an enable and a clear from the FSM.

Test Plan:
- P=8, 8N1, byte 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid 1 cycle, parity_error=0, stop_error=0; rx_valid rises 1 cycle after the stop decision.
- P=16, 8E1, 0x03 sent with parity bit 1 (wrong) -> rx_data=0x03, parity_error=1. Then 8O1 on 0x03 with parity 1 -> parity_error=0.
- P=8, line low for 3 cycles then high -> no rx_valid, FSM returns to IDLE at START majority; a subsequent 0x5A frame is received correctly.
- rx_ready=0, two frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; raising rx_ready pops 0x11 and rx_valid drops.
- DATA_WIDTH=7, two_stop=1, 0x7F with the second stop bit 0 -> stop_error=1, rx_data=0x7F; line held low for a full frame with par_en=1 -> break_det pulse, no rx_valid.
- rst asserted mid-DATA of 0xC3, then a clean 0x3C -> no partial word, only 0x3C delivered, all flags 0.
